// File: rtl/axi_lite_slave_demux.sv
// AXI-Lite 1-to-N demultiplexer: an external address map picks the slave and
// translates the address; unmapped selects are answered locally with DECERR.
module axi_lite_slave_demux #(
    parameter int ADDR_SIZE = 32,
    parameter int DATA_SIZE = 32,
    parameter int SELECT    = 4,
    parameter int N_SLAVES  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            s_awvalid,
    output logic                            s_awready,
    input  logic [ADDR_SIZE-1:0]            s_awaddr,
    input  logic                            s_wvalid,
    output logic                            s_wready,
    input  logic [DATA_SIZE-1:0]            s_wdata,
    input  logic [DATA_SIZE/8-1:0]          s_wstrb,
    output logic                            s_bvalid,
    input  logic                            s_bready,
    output logic [1:0]                      s_bresp,
    input  logic                            s_arvalid,
    output logic                            s_arready,
    input  logic [ADDR_SIZE-1:0]            s_araddr,
    output logic                            s_rvalid,
    input  logic                            s_rready,
    output logic [DATA_SIZE-1:0]            s_rdata,
    output logic [1:0]                      s_rresp,
    output logic [ADDR_SIZE-1:0]            wmap_addr_in,
    input  logic [ADDR_SIZE-1:0]            wmap_addr_out,
    input  logic [SELECT-1:0]               wmap_select,
    output logic [ADDR_SIZE-1:0]            rmap_addr_in,
    input  logic [ADDR_SIZE-1:0]            rmap_addr_out,
    input  logic [SELECT-1:0]               rmap_select,
    output logic [N_SLAVES-1:0]             m_awvalid,
    input  logic [N_SLAVES-1:0]             m_awready,
    output logic [ADDR_SIZE-1:0]            m_awaddr,
    output logic [N_SLAVES-1:0]             m_wvalid,
    input  logic [N_SLAVES-1:0]             m_wready,
    output logic [DATA_SIZE-1:0]            m_wdata,
    output logic [DATA_SIZE/8-1:0]          m_wstrb,
    input  logic [N_SLAVES-1:0]             m_bvalid,
    output logic [N_SLAVES-1:0]             m_bready,
    input  logic [2*N_SLAVES-1:0]           m_bresp,
    output logic [N_SLAVES-1:0]             m_arvalid,
    input  logic [N_SLAVES-1:0]             m_arready,
    output logic [ADDR_SIZE-1:0]            m_araddr,
    input  logic [N_SLAVES-1:0]             m_rvalid,
    output logic [N_SLAVES-1:0]             m_rready,
    input  logic [DATA_SIZE*N_SLAVES-1:0]   m_rdata,
    input  logic [2*N_SLAVES-1:0]           m_rresp
);
    localparam int unsigned N_LIM = N_SLAVES;

    typedef enum logic [1:0] {W_IDLE, W_FWD, W_RESP, W_ERR} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FWD, R_DATA, R_ERR} r_state_t;

    w_state_t               w_state, w_next;
    r_state_t               r_state, r_next;
    logic [SELECT-1:0]      wsel, rsel;
    logic [N_SLAVES-1:0]    wsel_oh, rsel_oh;
    logic                   aw_pend, w_pend, b_done, r_done;
    logic                   w_accept, aw_hs, w_hs, b_hs, w_err;
    logic                   r_accept, ar_hs, r_hs, r_err;
    logic [1:0]             bresp_sel, rresp_sel;
    logic [DATA_SIZE-1:0]   rdata_sel;

    assign wmap_addr_in = s_awaddr;
    assign rmap_addr_in = s_araddr;
    assign w_err = (32'(wmap_select) >= N_LIM);
    assign r_err = (32'(rmap_select) >= N_LIM);

    // Registered select decoded to one-hot; out-of-range values decode to all zeros.
    always_comb begin
        wsel_oh   = '0;
        rsel_oh   = '0;
        bresp_sel = 2'b00;
        rresp_sel = 2'b00;
        rdata_sel = '0;
        for (int i = 0; i < N_SLAVES; i++) begin
            wsel_oh[i] = (wsel == SELECT'(i));
            rsel_oh[i] = (rsel == SELECT'(i));
            if (wsel_oh[i]) bresp_sel = m_bresp[2*i +: 2];
            if (rsel_oh[i]) begin
                rdata_sel = m_rdata[DATA_SIZE*i +: DATA_SIZE];
                rresp_sel = m_rresp[2*i +: 2];
            end
        end
    end

    always_comb begin
        w_next    = w_state;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        m_awvalid = '0;
        m_wvalid  = '0;
        m_bready  = '0;
        w_accept  = 1'b0;
        aw_hs     = 1'b0;
        w_hs      = 1'b0;
        b_hs      = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                w_accept  = s_awvalid & s_wvalid;
                s_awready = w_accept;
                s_wready  = w_accept;
                if (w_accept) w_next = w_err ? W_ERR : W_FWD;
            end
            W_FWD: begin
                // Address and data legs retire independently.
                m_awvalid = aw_pend ? wsel_oh : '0;
                m_wvalid  = w_pend ? wsel_oh : '0;
                aw_hs     = |(m_awvalid & m_awready);
                w_hs      = |(m_wvalid & m_wready);
                if ((!aw_pend || aw_hs) && (!w_pend || w_hs)) w_next = W_RESP;
            end
            W_RESP: begin
                m_bready = b_done ? '0 : wsel_oh;
                b_hs     = |(m_bready & m_bvalid);
                s_bvalid = b_done;
                if (b_done && s_bready) w_next = W_IDLE;
            end
            W_ERR: begin
                s_bvalid = 1'b1;
                if (s_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) w_state <= W_IDLE;
        else        w_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wsel     <= '0;
            m_awaddr <= '0;
            m_wdata  <= '0;
            m_wstrb  <= '0;
            s_bresp  <= 2'b00;
            aw_pend  <= 1'b0;
            w_pend   <= 1'b0;
            b_done   <= 1'b0;
        end else begin
            if (w_accept) begin
                wsel     <= wmap_select;
                m_awaddr <= wmap_addr_out;
                m_wdata  <= s_wdata;
                m_wstrb  <= s_wstrb;
                aw_pend  <= ~w_err;
                w_pend   <= ~w_err;
                b_done   <= 1'b0;
                if (w_err) s_bresp <= 2'b11;
            end
            if (aw_hs) aw_pend <= 1'b0;
            if (w_hs)  w_pend  <= 1'b0;
            if (b_hs) begin
                s_bresp <= bresp_sel;
                b_done  <= 1'b1;
            end
        end
    end

    always_comb begin
        r_next    = r_state;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        m_arvalid = '0;
        m_rready  = '0;
        r_accept  = 1'b0;
        ar_hs     = 1'b0;
        r_hs      = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                r_accept  = s_arvalid;
                s_arready = s_arvalid;
                if (r_accept) r_next = r_err ? R_ERR : R_FWD;
            end
            R_FWD: begin
                m_arvalid = rsel_oh;
                ar_hs     = |(m_arvalid & m_arready);
                if (ar_hs) r_next = R_DATA;
            end
            R_DATA: begin
                m_rready = r_done ? '0 : rsel_oh;
                r_hs     = |(m_rready & m_rvalid);
                s_rvalid = r_done;
                if (r_done && s_rready) r_next = R_IDLE;
            end
            R_ERR: begin
                s_rvalid = 1'b1;
                if (s_rready) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= R_IDLE;
        else        r_state <= r_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsel     <= '0;
            m_araddr <= '0;
            s_rdata  <= '0;
            s_rresp  <= 2'b00;
            r_done   <= 1'b0;
        end else begin
            if (r_accept) begin
                rsel     <= rmap_select;
                m_araddr <= rmap_addr_out;
                r_done   <= 1'b0;
                if (r_err) begin
                    s_rdata <= '0;
                    s_rresp <= 2'b11;
                end
            end
            if (r_hs) begin
                s_rdata <= rdata_sel;
                s_rresp <= rresp_sel;
                r_done  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_slave_demux.sv
// Scoreboard bench for axi_lite_slave_demux: the bench acts as master, address map
// and slaves; expected transfers are queued at issue and checked by a monitor.
module tb_axi_lite_slave_demux;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int NS  = 8;
    localparam int STW = DW/8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [AW-1:0]     s_awaddr, s_araddr;
    logic [DW-1:0]     s_wdata, s_rdata;
    logic [STW-1:0]    s_wstrb, m_wstrb;
    logic [1:0]        s_bresp, s_rresp;
    logic              s_arvalid, s_arready, s_rvalid, s_rready;
    logic [AW-1:0]     wmap_addr_in, wmap_addr_out, rmap_addr_in, rmap_addr_out;
    logic [SW-1:0]     wmap_select, rmap_select;
    logic [NS-1:0]     m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [NS-1:0]     m_arvalid, m_arready, m_rvalid, m_rready;
    logic [AW-1:0]     m_awaddr, m_araddr;
    logic [DW-1:0]     m_wdata;
    logic [2*NS-1:0]   m_bresp, m_rresp;
    logic [DW*NS-1:0]  m_rdata;

    axi_lite_slave_demux #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .SELECT(SW), .N_SLAVES(NS)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .wmap_addr_in(wmap_addr_in), .wmap_addr_out(wmap_addr_out), .wmap_select(wmap_select),
        .rmap_addr_in(rmap_addr_in), .rmap_addr_out(rmap_addr_out), .rmap_select(rmap_select),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
    );

    int checks = 0;
    int errors = 0;

    int cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0, cfg_ar_dly = 0;
    int cfg_bhold = 0, cfg_rhold = 0;
    logic [SW-1:0] cfg_wsel = '0, cfg_rsel = '0;
    logic [1:0]    cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [DW-1:0] cfg_rdata = '0;

    logic [NS+AW-1:0]      exp_aw[$];
    logic [NS+AW-1:0]      exp_ar[$];
    logic [NS+DW+STW-1:0]  exp_w[$];
    logic [1:0]            exp_b[$];
    logic [DW+1:0]         exp_r[$];

    function automatic logic [NS-1:0] onehot(input logic [SW-1:0] s);
        logic [NS-1:0] v = '0;
        for (int i = 0; i < NS; i++) if (int'(s) == i) v[i] = 1'b1;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
        end
    endtask

    task automatic fail_unexpected(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s actual=%0h expected=no transfer", name, act);
    endtask

    // Slave-side response data: only the slot of the expected slave carries the
    // configured values, every other slot carries distinct junk.
    always_comb begin
        m_bresp = {NS{2'b01}};
        m_rresp = {NS{2'b10}};
        m_rdata = '0;
        for (int i = 0; i < NS; i++) begin
            m_rdata[DW*i +: DW] = 32'hBAD0_0000 + i;
            if (int'(cfg_wsel) == i) m_bresp[2*i +: 2] = cfg_bresp;
            if (int'(cfg_rsel) == i) begin
                m_rdata[DW*i +: DW] = cfg_rdata;
                m_rresp[2*i +: 2]   = cfg_rresp;
            end
        end
    end

    initial begin
        int wcnt = 0, bcnt = 0, rcnt = 0;
        m_awready = '0; m_wready = '0; m_bvalid = '0;
        m_arready = '0; m_rvalid = '0;
        forever begin
            @(posedge clk); #1;
            if (|m_awvalid || |m_wvalid || |m_bready) begin
                m_awready = (wcnt >= cfg_aw_dly) ? '1 : '0;
                m_wready  = (wcnt >= cfg_w_dly) ? '1 : '0;
                if (|m_bready) begin
                    m_bvalid = (bcnt >= cfg_b_dly) ? '1 : '0;
                    bcnt++;
                end else begin
                    m_bvalid = '0;
                    bcnt = 0;
                end
                wcnt++;
            end else begin
                m_awready = '0; m_wready = '0; m_bvalid = '0;
                wcnt = 0; bcnt = 0;
            end
            if (|m_arvalid || |m_rready) begin
                m_arready = (rcnt >= cfg_ar_dly) ? '1 : '0;
                m_rvalid  = (|m_rready) ? '1 : '0;
                rcnt++;
            end else begin
                m_arready = '0; m_rvalid = '0;
                rcnt = 0;
            end
        end
    end

    initial begin
        int bc = 0, rc = 0;
        s_bready = 1'b0; s_rready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (s_bvalid) begin s_bready = (bc >= cfg_bhold); bc++; end
            else begin s_bready = 1'b0; bc = 0; end
            if (s_rvalid) begin s_rready = (rc >= cfg_rhold); rc++; end
            else begin s_rready = 1'b0; rc = 0; end
        end
    end

    initial begin
        logic [NS-1:0] p_awv, p_wv, p_arv;
        logic [AW-1:0] p_awaddr, p_araddr;
        logic [DW-1:0] p_wdata, p_rdata;
        logic          p_bh, p_rh;
        logic [1:0]    p_bresp, p_rresp;
        p_awv = '0; p_wv = '0; p_arv = '0; p_bh = 1'b0; p_rh = 1'b0;
        p_awaddr = '0; p_araddr = '0; p_wdata = '0; p_rdata = '0; p_bresp = '0; p_rresp = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                p_awv = '0; p_wv = '0; p_arv = '0; p_bh = 1'b0; p_rh = 1'b0;
            end else begin
                if (s_awvalid) check("wmap_addr_in", wmap_addr_in, s_awaddr);
                if (s_arvalid) check("rmap_addr_in", rmap_addr_in, s_araddr);
                if (|p_awv) check("awvalid_hold", {m_awvalid, m_awaddr}, {p_awv, p_awaddr});
                if (|p_wv)  check("wvalid_hold", {m_wvalid, m_wdata}, {p_wv, p_wdata});
                if (|p_arv) check("arvalid_hold", {m_arvalid, m_araddr}, {p_arv, p_araddr});
                if (p_bh) check("bresp_stable", {s_bvalid, s_bresp}, {1'b1, p_bresp});
                if (p_rh) check("rdata_stable", {s_rvalid, s_rresp, s_rdata}, {1'b1, p_rresp, p_rdata});

                if (|(m_awvalid & m_awready)) begin
                    if (exp_aw.size() == 0) fail_unexpected("aw_unexpected", {m_awvalid, m_awaddr});
                    else check("aw_xfer", {m_awvalid, m_awaddr}, exp_aw.pop_front());
                end
                if (|(m_wvalid & m_wready)) begin
                    if (exp_w.size() == 0) fail_unexpected("w_unexpected", {m_wvalid, m_wdata, m_wstrb});
                    else check("w_xfer", {m_wvalid, m_wdata, m_wstrb}, exp_w.pop_front());
                end
                if (|(m_arvalid & m_arready)) begin
                    if (exp_ar.size() == 0) fail_unexpected("ar_unexpected", {m_arvalid, m_araddr});
                    else check("ar_xfer", {m_arvalid, m_araddr}, exp_ar.pop_front());
                end
                if (s_bvalid && s_bready) begin
                    if (exp_b.size() == 0) fail_unexpected("b_unexpected", s_bresp);
                    else check("bresp", s_bresp, exp_b.pop_front());
                end
                if (s_rvalid && s_rready) begin
                    if (exp_r.size() == 0) fail_unexpected("r_unexpected", {s_rresp, s_rdata});
                    else check("rresp_rdata", {s_rresp, s_rdata}, exp_r.pop_front());
                end

                p_awv = (|(m_awvalid & m_awready)) ? '0 : m_awvalid;
                p_wv  = (|(m_wvalid & m_wready)) ? '0 : m_wvalid;
                p_arv = (|(m_arvalid & m_arready)) ? '0 : m_arvalid;
                p_awaddr = m_awaddr; p_wdata = m_wdata; p_araddr = m_araddr;
                p_bh = s_bvalid & ~s_bready; p_bresp = s_bresp;
                p_rh = s_rvalid & ~s_rready; p_rresp = s_rresp; p_rdata = s_rdata;
            end
        end
    end

    task automatic push_write(input logic [SW-1:0] sel, input logic [AW-1:0] aout,
                              input logic [DW-1:0] data, input logic [STW-1:0] strb,
                              input logic [1:0] bresp);
        if (int'(sel) < NS) begin
            exp_aw.push_back({onehot(sel), aout});
            exp_w.push_back({onehot(sel), data, strb});
            exp_b.push_back(bresp);
        end else begin
            exp_b.push_back(2'b11);
        end
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [STW-1:0] strb, input logic [SW-1:0] sel,
                            input logic [AW-1:0] aout, input logic [1:0] bresp, input int lat_exp);
        int n = 0;
        @(posedge clk); #1;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb;
        wmap_select = sel; wmap_addr_out = aout;
        cfg_wsel = sel; cfg_bresp = bresp;
        push_write(sel, aout, data, strb, bresp);
        s_awvalid = 1'b1; s_wvalid = 1'b1;
        @(negedge clk);
        while (!(s_awready && s_wready) && n < 50) begin @(negedge clk); n++; end
        check("w_accept", {s_awready, s_wready}, 2'b11);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        if (lat_exp >= 0) begin
            n = 1;
            @(negedge clk);
            while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
            check("w_latency", n, lat_exp);
        end
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [SW-1:0] sel,
                           input logic [AW-1:0] aout, input logic [DW-1:0] rdata,
                           input logic [1:0] rresp);
        int n = 0;
        @(posedge clk); #1;
        s_araddr = addr; rmap_select = sel; rmap_addr_out = aout;
        cfg_rsel = sel; cfg_rdata = rdata; cfg_rresp = rresp;
        if (int'(sel) < NS) begin
            exp_ar.push_back({onehot(sel), aout});
            exp_r.push_back({rresp, rdata});
        end else begin
            exp_r.push_back({2'b11, 32'h0});
        end
        s_arvalid = 1'b1;
        @(negedge clk);
        while (!s_arready && n < 50) begin @(negedge clk); n++; end
        check("r_accept", s_arready, 1'b1);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_aw.size() + exp_w.size() + exp_b.size() + exp_ar.size() + exp_r.size()) != 0
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", (n < 200), 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_s_ctrl"}, {s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, '0);
        check({tag, "_m_ctrl"}, {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, '0);
    endtask

    initial begin
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        wmap_addr_out = '0; wmap_select = '0; rmap_addr_out = '0; rmap_select = '0;
        repeat (3) @(negedge clk);
        check_quiet("rst");
        check("rst_s_data", {s_bresp, s_rresp, s_rdata}, '0);
        check("rst_m_addr", {m_awaddr, m_araddr}, '0);
        check("rst_m_wdata", {m_wdata, m_wstrb}, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Basic write, zero-wait slave, latency measured
        do_write(32'h1910_2004, 32'hDEAD_BEEF, 4'hF, 4'd2, 32'h004, 2'b00, 3);
        drain();

        // Basic read
        do_read(32'h0000_8010, 4'd5, 32'h10, 32'h1234_5678, 2'b00);
        drain();

        // Unmapped selects answered locally
        do_write(32'hF000_0000, 32'h0BAD_F00D, 4'h3, 4'd8, 32'h0, 2'b00, -1);
        drain();
        do_read(32'hF000_0004, 4'd8, 32'h4, 32'hAAAA_5555, 2'b00);
        drain();
        do_read(32'hFFFF_FFFC, 4'd15, 32'hC, 32'h5555_AAAA, 2'b00);
        drain();

        // Address alone must not be accepted
        @(posedge clk); #1;
        s_awaddr = 32'h5000_0040; wmap_select = 4'd1; wmap_addr_out = 32'h40;
        s_wdata = 32'h0F0F_0F0F; s_wstrb = 4'hC; cfg_wsel = 4'd1; cfg_bresp = 2'b00;
        s_awvalid = 1'b1; s_wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("aw_alone_ready", {s_awready, s_wready}, 2'b00);
        end
        @(posedge clk); #1;
        push_write(4'd1, 32'h40, 32'h0F0F_0F0F, 4'hC, 2'b00);
        s_wvalid = 1'b1;
        @(negedge clk);
        check("aw_w_together", {s_awready, s_wready}, 2'b11);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        drain();

        // Slow data leg, SLVERR from slave, master stalls the response
        cfg_aw_dly = 0; cfg_w_dly = 3; cfg_bhold = 4;
        do_write(32'h2000_0100, 32'hCAFE_F00D, 4'b0101, 4'd7, 32'h100, 2'b10, -1);
        drain();
        // Slow address leg
        cfg_aw_dly = 2; cfg_w_dly = 0; cfg_bhold = 0;
        do_write(32'h2000_0200, 32'h0000_00A5, 4'b1000, 4'd6, 32'h200, 2'b00, -1);
        drain();
        cfg_aw_dly = 0;

        // Slow read address, stalled read response, EXOKAY from slave 0
        cfg_ar_dly = 2; cfg_rhold = 3;
        do_read(32'h3000_0020, 4'd0, 32'h20, 32'h8765_4321, 2'b01);
        drain();
        cfg_ar_dly = 0; cfg_rhold = 0;

        // Read and write in flight together to the same slave
        do_write(32'h6000_0008, 32'h1357_9BDF, 4'hF, 4'd3, 32'h8, 2'b00, -1);
        do_read(32'h6000_000C, 4'd3, 32'hC, 32'h2468_ACE0, 2'b00);
        drain();

        // Reset in the middle of a write response wait and a read forward
        cfg_b_dly = 30; cfg_ar_dly = 30;
        do_write(32'h4000_0000, 32'h1111_2222, 4'hF, 4'd1, 32'h8, 2'b00, -1);
        do_read(32'h4000_0010, 4'd6, 32'h18, 32'h3333_4444, 2'b00);
        repeat (2) @(negedge clk);
        check("pre_rst_bready", m_bready, 8'b0000_0010);
        check("pre_rst_arvalid", m_arvalid, 8'b0100_0000);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        check_quiet("midrst");
        exp_aw.delete(); exp_w.delete(); exp_b.delete(); exp_ar.delete(); exp_r.delete();
        cfg_b_dly = 0; cfg_ar_dly = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_write(32'h7000_0030, 32'hFACE_0001, 4'hF, 4'd4, 32'h30, 2'b00, 3);
        drain();
        do_read(32'h7000_0034, 4'd2, 32'h34, 32'h0BEE_F00D, 2'b00);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
